apb_regbank: RTL

APB_REGBANK -- requirements
Module: apb_regbank

---
 rtl/apb_regbank.sv | 128 ++++++++++++
 1 files changed

// File: rtl/apb_regbank.sv
// APB slave register bank: NREG word registers, optional read-only slots sourced
// from ro_i, configurable access-phase wait states and error response.
module apb_regbank #(
    parameter int unsigned     NREG    = 8,
    parameter int unsigned     DW      = 32,
    parameter int unsigned     AW      = 16,
    parameter int unsigned     WAIT    = 0,
    parameter logic [NREG-1:0] RO_MASK = '0
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [AW-1:0]      paddr,
    input  logic [DW-1:0]      pwdata,
    input  logic [DW/8-1:0]    pstrb,
    output logic [DW-1:0]      prdata,
    output logic               pready,
    output logic               pslverr,
    input  logic [NREG*DW-1:0] ro_i,
    output logic [NREG*DW-1:0] regs_o,
    output logic [NREG-1:0]    wr_pulse
);

    localparam int unsigned NB   = DW / 8;
    localparam int unsigned IW   = AW - 2;
    localparam int unsigned CW   = 3;
    localparam int unsigned CMPW = (IW > 7) ? IW + 1 : 8;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx_c;
    logic [NREG-1:0] hit_c;
    logic            idx_ok_c;
    logic            err_c;
    logic            commit_c;
    logic [DW-1:0]   rd_src_c;
    logic [DW-1:0]   rd_acc [NREG+1];
    logic [NREG-1:0] unused_ro;

    assign idx_c    = paddr[AW-1:2];
    assign idx_ok_c = CMPW'(idx_c) < CMPW'(NREG);
    assign err_c    = (paddr[1:0] != 2'b00) || !idx_ok_c || (pwrite && |(hit_c & RO_MASK));

    // Completion is qualified by the live bus so a dropped psel never completes.
    assign pready   = presetn && (state == ACCESS) && (cnt == '0) && psel && penable;
    assign pslverr  = pready && err_c;
    assign commit_c = pready && pwrite && !err_c;

    assign rd_acc[0] = '0;
    assign rd_src_c  = rd_acc[NREG];

    for (genvar k = 0; k < NREG; k++) begin : g_reg
        logic [DW-1:0] src;
        logic          pulse_q;

        assign hit_c[k]       = (idx_c == IW'(k));
        assign rd_acc[k+1]    = rd_acc[k] | (hit_c[k] ? src : '0);
        assign wr_pulse[k]    = pulse_q;

        always_ff @(posedge pclk) begin
            if (!presetn) begin
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= commit_c && hit_c[k];
            end
        end

        if (RO_MASK[k]) begin : g_ro
            assign src                = ro_i[k*DW +: DW];
            assign regs_o[k*DW +: DW] = '0;
            assign unused_ro[k]       = 1'b0;
        end else begin : g_rw
            logic [DW-1:0] q;

            assign src                = q;
            assign regs_o[k*DW +: DW] = q;
            // ro_i slices of writable registers are intentionally ignored.
            assign unused_ro[k]       = ^ro_i[k*DW +: DW];

            for (genvar b = 0; b < NB; b++) begin : g_byte
                always_ff @(posedge pclk) begin
                    if (!presetn) begin
                        q[b*8 +: 8] <= '0;
                    end else if (commit_c && hit_c[k] && pstrb[b]) begin
                        q[b*8 +: 8] <= pwdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Transfer FSM; read data is captured at the setup edge.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state  <= IDLE;
            cnt    <= '0;
            prdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        state <= ACCESS;
                        cnt   <= CW'(WAIT);
                        if (!pwrite) begin
                            prdata <= err_c ? '0 : rd_src_c;
                        end
                    end
                end
                ACCESS: begin
                    if (pready || !psel) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
